// File: rtl/block_transfer_sequencer.sv
// block_transfer_sequencer: sequences LDM/STM block transfers between the
// register file and the memory interface, with optional base writeback.
// Optional feature macro: BTS_ACK_TIMEOUT_EN adds a 16-cycle mem_ack
// timeout that aborts the transfer and pulses the extra abort output.
module block_transfer_sequencer #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned NREGS      = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic             load,
  input  logic             P,
  input  logic             U,
  input  logic             W,
  input  logic [3:0]       base_reg,
  input  logic [31:0]      base,
  input  logic [NREGS-1:0] reg_list,
  output logic [3:0]       reg_addr,
  input  logic [31:0]      reg_rdata,
  output logic [31:0]      reg_wdata,
  output logic             RW,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done
`ifdef BTS_ACK_TIMEOUT_EN
  ,
  output logic             abort
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, WB, FIN} stateT;

  localparam logic [31:0]      STEP    = 32'(WORD_BYTES);
  localparam logic [NREGS-1:0] ONE_BIT = NREGS'(1);

  stateT            state, stateNext;
  logic [NREGS-1:0] listR;
  logic [31:0]      baseR;
  logic [3:0]       baseRegR;
  logic             pR, uR, wR, loadR, baseInList;
  logic [31:0]      curAddr, wbValue;
  logic             gapR;
`ifdef BTS_ACK_TIMEOUT_EN
  logic [3:0]       tmoR;
  logic             abortR;
`endif

  logic [4:0]       popCnt;
  logic [3:0]       lowIdx;
  logic [NREGS-1:0] listAfter;
  logic [31:0]      span, firstAddr;

  // Number of registers still in the latched list.
  always_comb begin
    popCnt = '0;
    for (int unsigned i = 0; i < NREGS; i++) popCnt = popCnt + 5'(listR[i]);
  end

  // Lowest set bit of the list: descending scan so the lowest index wins.
  always_comb begin
    lowIdx = '0;
    for (int unsigned i = NREGS; i > 0; i--) begin
      if (listR[i-1]) lowIdx = 4'(i - 1);
    end
  end

  // Block span, first address by addressing mode, and list after servicing.
  always_comb begin
    span      = 32'(popCnt) * STEP;
    listAfter = listR & ~(ONE_BIT << lowIdx);
    case ({pR, uR})
      2'b01:   firstAddr = baseR;
      2'b11:   firstAddr = baseR + STEP;
      2'b00:   firstAddr = baseR - span + STEP;
      default: firstAddr = baseR - span;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!CLR) state <= IDLE;
    else      state <= stateNext;
  end

  // Latched request, address/writeback values, inter-transfer gap and timeout.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      listR      <= '0;
      baseR      <= '0;
      baseRegR   <= '0;
      pR         <= 1'b0;
      uR         <= 1'b0;
      wR         <= 1'b0;
      loadR      <= 1'b0;
      baseInList <= 1'b0;
      curAddr    <= '0;
      wbValue    <= '0;
      gapR       <= 1'b0;
`ifdef BTS_ACK_TIMEOUT_EN
      tmoR       <= '0;
      abortR     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          gapR <= 1'b0;
`ifdef BTS_ACK_TIMEOUT_EN
          tmoR   <= '0;
          abortR <= 1'b0;
`endif
          if (start) begin
            listR      <= reg_list;
            baseR      <= base;
            baseRegR   <= base_reg;
            pR         <= P;
            uR         <= U;
            wR         <= W;
            loadR      <= load;
            baseInList <= reg_list[base_reg];
          end
        end
        SETUP: begin
          curAddr <= firstAddr;
          wbValue <= uR ? (baseR + span) : (baseR - span);
          gapR    <= 1'b0;
        end
        XFER: begin
          if (gapR) begin
            gapR <= 1'b0;
          end else if (mem_ack) begin
            listR   <= listAfter;
            curAddr <= curAddr + STEP;
            gapR    <= 1'b1;
`ifdef BTS_ACK_TIMEOUT_EN
            tmoR    <= '0;
          end else if (tmoR == 4'hF) begin
            abortR  <= 1'b1;
          end else begin
            tmoR    <= tmoR + 4'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs; RW is gated by CLR so a reset edge never writes.
  always_comb begin
    stateNext = state;
    reg_addr  = '0;
    reg_wdata = '0;
    RW        = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef BTS_ACK_TIMEOUT_EN
    abort     = 1'b0;
`endif
    case (state)
      IDLE: if (start) stateNext = SETUP;
      SETUP: begin
        busy      = 1'b1;
        stateNext = (popCnt == 5'd0) ? FIN : XFER;
      end
      XFER: begin
        busy     = 1'b1;
        reg_addr = lowIdx;
        if (!gapR) begin
          mem_req  = 1'b1;
          mem_we   = ~loadR;
          mem_addr = curAddr;
          if (!loadR) mem_wdata = reg_rdata;
          if (mem_ack) begin
            if (loadR) begin
              RW        = CLR;
              reg_wdata = mem_rdata;
            end
            if (listAfter == '0) stateNext = wR ? WB : FIN;
`ifdef BTS_ACK_TIMEOUT_EN
          end else if (tmoR == 4'hF) begin
            stateNext = FIN;
`endif
          end
        end
      end
      WB: begin
        busy      = 1'b1;
        reg_addr  = baseRegR;
        reg_wdata = wbValue;
        RW        = CLR & ~(loadR & baseInList);
        stateNext = FIN;
      end
      FIN: begin
        done      = 1'b1;
`ifdef BTS_ACK_TIMEOUT_EN
        abort     = abortR;
`endif
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Scoreboard testbench for block_transfer_sequencer: a transaction-level
// model queues expected memory transfers, register writes and done pulses;
// a negedge monitor compares DUT activity against the queue heads.
module tb_block_transfer_sequencer;

  localparam int ACK_NEVER  = 0;
  localparam int ACK_ALWAYS = 1;
  localparam int ACK_STALL  = 2;

  logic        CLK = 1'b0, CLR = 1'b0, start = 1'b0;
  logic        load = 1'b0, P = 1'b0, U = 1'b0, W = 1'b0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base = '0;
  logic [15:0] reg_list = '0;
  logic [3:0]  reg_addr;
  logic [31:0] reg_rdata, reg_wdata, mem_addr, mem_wdata, mem_rdata;
  logic        RW, mem_req, mem_we, busy, done;
  logic        mem_ack = 1'b0;
`ifdef BTS_ACK_TIMEOUT_EN
  logic        abort;
`endif

  int          errors = 0, checks = 0;
  int unsigned cyc = 0;
  int          ackMode = ACK_ALWAYS;
  logic [31:0] regVals [16];

  typedef struct { logic [31:0] addr; logic [3:0] rg; logic we; } xferT;
  typedef struct { logic [3:0] rg; logic [31:0] data; } wrT;
  xferT xferQ[$];
  wrT   wrQ[$];
  logic doneQ[$];

  function automatic logic [31:0] memFunc(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign mem_rdata = memFunc(mem_addr);
  assign reg_rdata = regVals[reg_addr];

  block_transfer_sequencer #(.WORD_BYTES(4), .NREGS(16)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .load(load), .P(P), .U(U), .W(W),
    .base_reg(base_reg), .base(base), .reg_list(reg_list),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .reg_wdata(reg_wdata),
    .RW(RW), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done)
`ifdef BTS_ACK_TIMEOUT_EN
    , .abort(abort)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_reg_wdata"}, reg_wdata, 32'd0);
    check({tag, "_RW"}, 32'(RW), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Memory responder: ack always, never, or after a random 0..5 cycle stall.
  initial begin
    int unsigned stall = 0, target = 0;
    forever begin
      @(posedge CLK); #1;
      if (ackMode == ACK_ALWAYS) mem_ack = 1'b1;
      else if (ackMode == ACK_NEVER || !mem_req) mem_ack = 1'b0;
      else if (stall >= target) begin
        mem_ack = 1'b1;
        stall   = 0;
        target  = $urandom_range(0, 5);
      end else begin
        mem_ack = 1'b0;
        stall++;
      end
    end
  end

  // Monitor: compare observed transfers, register writes and done pulses.
  always @(negedge CLK) begin
    xferT e;
    wrT   w;
    logic ab;
    if (CLR) begin
      if (mem_req) begin
        if (xferQ.size() == 0) check("unexpected_mem_req", 32'(mem_req), 32'd0);
        else begin
          e = xferQ[0];
          check("mem_addr", mem_addr, e.addr);
          check("xfer_reg_addr", 32'(reg_addr), 32'(e.rg));
          check("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) check("mem_wdata", mem_wdata, regVals[e.rg]);
          if (mem_ack) void'(xferQ.pop_front());
        end
      end
      if (RW) begin
        if (wrQ.size() == 0) check("unexpected_RW", 32'(RW), 32'd0);
        else begin
          w = wrQ.pop_front();
          check("wr_reg_addr", 32'(reg_addr), 32'(w.rg));
          check("reg_wdata", reg_wdata, w.data);
        end
      end
      if (done) begin
        if (doneQ.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else begin
          ab = doneQ.pop_front();
          check("busy_at_done", 32'(busy), 32'd0);
`ifdef BTS_ACK_TIMEOUT_EN
          check("abort", 32'(abort), 32'(ab));
`else
          if (ab) check("abort_not_expected", 32'(ab), 32'd0);
`endif
        end
      end
    end
  end

  // Issue one transfer from posedge+1, queue its expected behaviour and wait
  // for done; returns at posedge+1 with the DUT back in IDLE.
  task automatic runTxn(input logic ld, input logic p, input logic u, input logic w,
                        input logic [3:0] br, input logic [31:0] b,
                        input logic [15:0] lst, input bit timeLat);
    int unsigned n, k, expLat, t0;
    logic [31:0] lowAddr, a;
    bit          abortExp, got;
    n        = $countones(lst);
    abortExp = (ackMode == ACK_NEVER) && (n > 0);
    // Block occupies n consecutive words; up-modes start at or after base,
    // down-modes end at or before base.
    if (u) lowAddr = b + (p ? 32'd4 : 32'd0);
    else   lowAddr = b - (p ? 32'd4 : 32'd0) - 32'(4 * n) + 32'd4;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i] && (!abortExp || k == 0)) begin
        a = lowAddr + 32'(4 * k);
        xferQ.push_back('{a, 4'(i), ~ld});
        if (ld && !abortExp) wrQ.push_back('{4'(i), memFunc(a)});
        k++;
      end
    end
    if (n > 0 && w && !abortExp && !(ld && lst[br]))
      wrQ.push_back('{br, u ? b + 32'(4 * n) : b - 32'(4 * n)});
    doneQ.push_back(abortExp);
    if (n == 0)        expLat = 2;
    else if (abortExp) expLat = 18;
    else               expLat = 1 + 2 * n + (w ? 1 : 0);

    load = ld; P = p; U = u; W = w; base_reg = br; base = b; reg_list = lst;
    start = 1'b1;
    t0 = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (done) begin got = 1'b1; break; end
      // Junk requests while busy must be ignored.
      start    = busy && ($urandom_range(0, 3) == 0);
      reg_list = 16'($urandom);
      base     = $urandom;
      load     = 1'($urandom);
    end
    start = 1'b0;
    if (!got) check("done_timeout", 32'(got), 32'd1);
    else if (timeLat) check("latency", cyc - t0, expLat);
    if (abortExp) xferQ.delete();
    @(posedge CLK); #1;
  endtask

  initial begin
    bit sawReq;
    for (int i = 0; i < 16; i++) regVals[i] = $urandom;

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkIdleOutputs("reset");
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(posedge CLK); #1;

    ackMode = ACK_ALWAYS;
    runTxn(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0000_1000, 16'h000F, 1'b1);
    runTxn(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_2000, 16'h8002, 1'b1);
    runTxn(1'b1, 1'b0, 1'b1, 1'b1, 4'd4,  32'h0000_3000, 16'h0010, 1'b1);
    runTxn(1'b0, 1'b0, 1'b0, 1'b1, 4'd2,  32'h0000_0040, 16'h0000, 1'b1);
    runTxn(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  32'h0000_0000, 16'hFFFF, 1'b1);
    runTxn(1'b0, 1'b1, 1'b1, 1'b1, 4'd5,  32'hFFFF_FFF8, 16'h0021, 1'b1);

    // Stall on the second transfer, then reset mid-XFER.
    xferQ.push_back('{32'h0000_5000, 4'd4, 1'b1});
    xferQ.push_back('{32'h0000_5004, 4'd5, 1'b1});
    load = 1'b0; P = 1'b0; U = 1'b1; W = 1'b1; base_reg = 4'd1;
    base = 32'h0000_5000; reg_list = 16'h00F0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    sawReq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (mem_req) begin sawReq = 1'b1; ackMode = ACK_NEVER; break; end
    end
    check("first_req_seen", 32'(sawReq), 32'd1);
    repeat (7) @(negedge CLK);
    check("stalled_req_held", 32'(mem_req), 32'd1);
    @(posedge CLK); #1;
    CLR = 1'b0;
    @(posedge CLK); #1;
    checkIdleOutputs("midreset");
    CLR = 1'b1;
    xferQ.delete();
    wrQ.delete();
    doneQ.delete();
    @(posedge CLK); #1;

`ifdef BTS_ACK_TIMEOUT_EN
    ackMode = ACK_NEVER;
    runTxn(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h0000_6000, 16'h0003, 1'b1);
    runTxn(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h0000_7000, 16'h0300, 1'b1);
`endif

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] lst;
      ackMode = ($urandom_range(0, 2) == 0) ? ACK_ALWAYS : ACK_STALL;
      case ($urandom_range(0, 3))
        0:       lst = 16'h0;
        1:       lst = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: lst = 16'($urandom);
      endcase
      runTxn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), $urandom, lst, ackMode == ACK_ALWAYS);
    end

    repeat (3) @(posedge CLK);
    check("xferQ_drained", 32'(xferQ.size()), 32'd0);
    check("wrQ_drained", 32'(wrQ.size()), 32'd0);
    check("doneQ_drained", 32'(doneQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
- Sequences ARM load/store-multiple (LDM/STM) transfers between the register file and the memory interface.
- For STM, it is the register file's reader: it drives a read address and forwards the read data to memory.
- For LDM, it is the register file's writer: it drives the write address, write data and RW strobe from memory read data.
- Sits beside the register file in the datapath and is started by the control unit once per block-transfer instruction.

Parameters:
- WORD_BYTES, 4, address increment per transferred register.
- NREGS, 16, register list width and number of architectural registers.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- CLR  input  1  synchronous active-low reset; sampled on rising CLK.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- load  input  1  1 = LDM (memory to registers), 0 = STM (registers to memory).
- P  input  1  pre-index (1) / post-index (0).
- U  input  1  up (1) / down (0).
- W  input  1  base writeback enable.
- base_reg  input  4  register number holding the base address.
- base  input  32  base address value.
- reg_list  input  16  register list; bit i selects Ri.
- reg_addr  output  4  register file read address (STM) / write address (LDM).
- reg_rdata  input  32  register file read data (STM).
- reg_wdata  output  32  register file write data.
- RW  output  1  register file write strobe, one cycle.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = memory write (STM).
- mem_addr  output  32  word address of the current transfer.
- mem_wdata  output  32  equals reg_rdata while mem_req and mem_we are high.
- mem_rdata  input  32  memory read data, valid with mem_ack.
- mem_ack  input  1  memory completes the current request.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse at completion.

Behaviour:
- Reset (CLR=0 at an edge):
  - State goes to IDLE from any state, including mid-transfer.
  - All outputs go to 0, and the latched list, count and addresses are cleared.
  - No RW pulse or writeback occurs in that cycle.
- States: IDLE, SETUP, XFER, WB, FIN.
- IDLE: on start=1, latch reg_list, base, base_reg, P, U, W and load, then go to SETUP. start is ignored in every other state.
- SETUP (1 cycle):
  - n = popcount(list), 0..16, held in 5 bits.
  - First address, by mode:
    - IA (P=0,U=1): base
    - IB (P=1,U=1): base+4
    - DA (P=0,U=0): base-4n+4
    - DB (P=1,U=0): base-4n
  - wb_value = U ? base+4n : base-4n. All arithmetic is mod 2^32.
  - If n=0: go to FIN; no transfers, no writeback.
  - Otherwise: go to XFER.
- XFER:
  - reg_addr = index of the lowest remaining set bit in the list.
  - mem_req=1, mem_we=~load, mem_addr = current address.
  - All three are held stable until mem_ack=1.
  - On the ack edge:
    - LDM: RW=1 for exactly that cycle, reg_wdata = mem_rdata.
    - Clear the serviced bit and advance the address by 4.
    - If the list is now empty, go to WB when W=1, else FIN.
  - Transfers are always in ascending register order at ascending addresses.
  - mem_req drops for 1 cycle between transfers.
- WB (1 cycle):
  - RW=1, reg_addr=base_reg, reg_wdata=wb_value.
  - Exception: LDM with the base_reg bit set in the original list suppresses writeback (RW stays 0), so the loaded value wins.
  - STM with the base in the list stores the original base value.
- FIN: done=1 for 1 cycle, busy=0, return to IDLE.
- busy is 1 in SETUP, XFER and WB.
- Latency (mem_ack tied high): 1 + 2n + (W?1:0) cycles from start to the done pulse.

Optional Feature:
- Macro: BTS_ACK_TIMEOUT_EN.
- When defined:
  - A 4-bit counter runs during each XFER request.
  - If mem_ack is still 0 after 16 cycles of mem_req, the transfer aborts: go to FIN with no writeback.
  - Extra output abort (1 bit) pulses together with done.
  - Registers already written stay written.
- When undefined: XFER waits indefinitely for mem_ack, and the abort port does not exist.

Test Plan:
- STM IA, W=0, list=16'h000F, base=32'h00001000, mem_ack=1:
  - addresses 0x1000, 0x1004, 0x1008, 0x100C, with reg_addr 0,1,2,3 and mem_we=1.
  - done at cycle 9; no RW.
- LDM DB, W=1, base_reg=13, base=32'h2000, list=16'h8002:
  - R1 loaded from 0x1FF8, R15 from 0x1FFC.
  - WB writes R13=0x1FF8.
- LDM IA, W=1, base_reg=4, list=16'h0010: R4 = mem_rdata; no writeback RW pulse.
- list=0, start: done 2 cycles later; mem_req and RW never asserted.
- mem_ack held low for 5 cycles on the second transfer: mem_addr and reg_addr stay stable; CLR=0 mid-XFER forces IDLE with all outputs 0 on the next edge.
- (BTS_ACK_TIMEOUT_EN) mem_ack never asserted: abort and done pulse 16 cycles after mem_req rises; no writeback.
